uart_rx_param: RTL and testbench

- Parametrised UART receiver: the next generation of the fixed 8-bit, always-parity serial receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority vote at mid-bit, per-frame error flags (parity, framing, break).
- Valid/ready output holding register with overrun detection; sits between the pad-side serial input and the byte-stream consumer.

---
 rtl/uart_rx_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver with 3-sample majority vote at mid-bit,
//   per-frame parity / framing / break flags and a valid/ready holding
//   register with sticky overrun detection.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   serial_data   asynchronous serial line, idles high
//   i_rx_ready    consumer accepts the held word when high with o_rx_valid
//   o_rx_valid    holding register contains an unconsumed frame
//   o_rx_data     received data word, bit 0 is the first bit on the line
//   o_parity_err  parity mismatch on the held frame
//   o_frame_err   a checked stop bit was low on the held frame
//   o_break       data, parity and first stop bit were all low
//   o_overrun     sticky: a completed frame was dropped while full
module uart_rx_param #(
    parameter int CLK_PER_BIT = 87,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_data,
    input  logic                 i_rx_ready,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int CW = $clog2(CLK_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_CNT  = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = 1'(PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [1:0]             r_hist;
    logic                   r_armed;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_allz;

    logic w_line;
    logic w_line_real;
    logic w_vote;
    logic w_tick;
    logic w_done;
    logic w_accept;
    logic w_ferr_final;
    logic w_brk_final;

    assign w_line   = r_sync[SYNC_STAGES-1];
    // The synchroniser resets to 1, so its output only reflects the real
    // pin once the reset-time contents have been flushed; arming waits for
    // that, otherwise a line held low through reset would look like a start.
    assign w_line_real = r_fill[SYNC_STAGES-1];
    assign w_vote   = (w_line & r_hist[0]) | (w_line & r_hist[1]) | (r_hist[0] & r_hist[1]);
    assign w_tick   = (r_cnt == LAST_CNT);
    assign w_done   = (r_state == S_STOP) && w_tick && (r_stop_idx == LAST_STOP);
    assign w_accept = ~o_rx_valid | i_rx_ready;

    // Final-sample flags include the vote taken in the completion cycle.
    assign w_ferr_final = r_ferr | ~w_vote;
    assign w_brk_final  = r_allz & (r_stop_idx | ~w_vote);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync       <= '1;
            r_fill       <= '0;
            r_hist       <= '1;
            r_armed      <= 1'b0;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_allz       <= 1'b0;
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial_data};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_hist <= {r_hist[0], w_line};
            if (w_line_real && w_line) begin
                r_armed <= 1'b1;
            end

            // Handshake first; a load in the same cycle overrides the clear.
            if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
                o_overrun  <= 1'b0;
            end
            if (w_done) begin
                if (w_accept) begin
                    o_rx_valid   <= 1'b1;
                    o_rx_data    <= r_shift;
                    o_parity_err <= (PARITY_MODE != 0) & r_perr;
                    o_frame_err  <= w_ferr_final;
                    o_break      <= w_brk_final;
                end else begin
                    o_overrun    <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_armed && !w_line) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        if (w_vote) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_DATA;
                            r_cnt      <= '0;
                            r_bit      <= '0;
                            r_stop_idx <= 1'b0;
                            r_par      <= 1'b0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_allz     <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt          <= '0;
                        r_shift[r_bit] <= w_vote;
                        r_par          <= r_par ^ w_vote;
                        r_allz         <= r_allz & ~w_vote;
                        if (r_bit == LAST_BIT) begin
                            r_state <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_perr  <= ((r_par ^ w_vote) != ODD_PAR);
                        r_allz  <= r_allz & ~w_vote;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                        if (!r_stop_idx) begin
                            r_allz <= r_allz & ~w_vote;
                        end
                        if (r_stop_idx == LAST_STOP) begin
                            r_state <= w_vote ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_line) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: config A (16 clk/bit, 8 data, even parity, 1 stop)
// and config B (16 clk/bit, 7 data, no parity, 2 stops).
module tb_uart_rx_param;

    localparam int BIT = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rx_t;

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       st;
        rx_t        exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0, rst_n_b = 1'b0;
    logic       serial_a = 1'b1, serial_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b0;
    logic       valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic       valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [7:0] data_a;
    logic [6:0] data_b;

    int n_pass = 0;
    int n_total = 0;

    rx_t  rxq_a[$];
    rx_t  rxq_b[$];
    rx_t  expq[$];
    vec_t vecs[7];

    logic [7:0] rd;
    logic       rpb, rstop, prev_st;
    int         gap;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_PER_BIT(BIT), .DATA_BITS(8), .PARITY_MODE(1),
                    .STOP_BITS(1), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .reset(rst_n_a), .serial_data(serial_a), .i_rx_ready(ready_a),
        .o_rx_valid(valid_a), .o_rx_data(data_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_break(brk_a), .o_overrun(ovr_a));

    uart_rx_param #(.CLK_PER_BIT(BIT), .DATA_BITS(7), .PARITY_MODE(0),
                    .STOP_BITS(2), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .reset(rst_n_b), .serial_data(serial_b), .i_rx_ready(ready_b),
        .o_rx_valid(valid_b), .o_rx_data(data_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_break(brk_b), .o_overrun(ovr_b));

    // Capture every accepted word, away from the active edge.
    always @(negedge clk) begin
        if (rst_n_a && valid_a && ready_a) rxq_a.push_back({1'b0, data_a, perr_a, ferr_a, brk_a});
        if (rst_n_b && valid_b && ready_b) rxq_b.push_back({2'b0, data_b, perr_b, ferr_b, brk_b});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: the frame contents decide the result directly.
    function automatic rx_t model_a(input logic [7:0] d, input logic pb, input logic st);
        rx_t r;
        r.data = {1'b0, d};
        r.perr = ((^d) ^ pb) != 1'b0;
        r.ferr = !st;
        r.brk  = (d == 8'h00) && !pb && !st;
        return r;
    endfunction

    task automatic frame_a(input logic [7:0] d, input logic pb, input logic st, input int spike);
        logic [10:0] bits;
        bits = {st, pb, d, 1'b0};
        for (int p = 0; p < 11 * BIT; p++) begin
            serial_a = bits[p / BIT] ^ (p == spike);
            tick(1);
        end
    endtask

    task automatic frame_b(input logic [6:0] d, input logic st2);
        logic [9:0] bits;
        bits = {st2, 1'b1, d, 1'b0};
        for (int p = 0; p < 10 * BIT; p++) begin
            serial_b = bits[p / BIT];
            tick(1);
        end
    endtask

    task automatic expect_a(input string nm, input rx_t e);
        rx_t g;
        if (rxq_a.size() == 0) begin
            check({nm, "_present"}, 32'(rxq_a.size()), 32'd1);
        end else begin
            g = rxq_a.pop_front();
            check(nm, 32'(g), 32'(e));
        end
    endtask

    task automatic expect_b(input string nm, input rx_t e);
        rx_t g;
        if (rxq_b.size() == 0) begin
            check({nm, "_present"}, 32'(rxq_b.size()), 32'd1);
        end else begin
            g = rxq_b.pop_front();
            check(nm, 32'(g), 32'(e));
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] d, input logic pb, input logic st,
                           input logic [7:0] ed, input logic ep, input logic ef, input logic eb);
        vecs[i].d   = d;
        vecs[i].pb  = pb;
        vecs[i].st  = st;
        vecs[i].exp = {1'b0, ed, ep, ef, eb};
    endtask

    initial begin
        //        data   par   stop  exp_data perr ferr brk
        set_vec(0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        set_vec(1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        set_vec(2, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        set_vec(3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        set_vec(4, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        set_vec(5, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        set_vec(6, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Reset state
        tick(3);
        check("a_reset_outs", 32'({valid_a, data_a, perr_a, ferr_a, brk_a, ovr_a}), 32'd0);
        check("b_reset_outs", 32'({valid_b, data_b, perr_b, ferr_b, brk_b, ovr_b}), 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick(2 * BIT);

        // Table-driven frames on config A
        for (int i = 0; i < 7; i++) begin
            serial_a = 1'b1;
            tick(2 * BIT);
            frame_a(vecs[i].d, vecs[i].pb, vecs[i].st, -1);
            serial_a = 1'b1;
            tick(BIT);
            expect_a($sformatf("vec%0d", i), vecs[i].exp);
            check($sformatf("vec%0d_single", i), 32'(rxq_a.size()), 32'd0);
        end

        // Long break: one frame only, held until the line returns high
        tick(2 * BIT);
        serial_a = 1'b0;
        tick(30 * BIT);
        check("brk_one_frame_while_low", 32'(rxq_a.size()), 32'd1);
        serial_a = 1'b1;
        tick(3 * BIT);
        expect_a("brk_frame", {1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
        check("brk_no_more", 32'(rxq_a.size()), 32'd0);

        // Overrun with back-to-back frames
        ready_a = 1'b0;
        tick(2 * BIT);
        frame_a(8'h11, 1'b0, 1'b1, -1);
        frame_a(8'h22, 1'b0, 1'b1, -1);
        serial_a = 1'b1;
        tick(BIT);
        check("ovr_valid", 32'(valid_a), 32'd1);
        check("ovr_data_held", 32'(data_a), 32'h11);
        check("ovr_flag", 32'(ovr_a), 32'd1);
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        check("ovr_valid_dropped", 32'(valid_a), 32'd0);
        check("ovr_flag_cleared", 32'(ovr_a), 32'd0);
        expect_a("ovr_word", {1'b0, 8'h11, 1'b0, 1'b0, 1'b0});
        ready_a = 1'b1;

        // Short low glitch on idle line
        tick(2 * BIT);
        serial_a = 1'b0;
        tick(4);
        serial_a = 1'b1;
        tick(3 * BIT);
        check("glitch_no_valid", 32'(valid_a), 32'd0);
        check("glitch_no_word", 32'(rxq_a.size()), 32'd0);

        // One-cycle spike inside the vote window of data bit 3
        frame_a(8'h55, 1'b0, 1'b1, 4 * BIT + 7);
        serial_a = 1'b1;
        tick(BIT);
        expect_a("spike_0x55", {1'b0, 8'h55, 1'b0, 1'b0, 1'b0});

        // Randomised frames against the reference model
        prev_st = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd    = 8'($urandom_range(0, 255));
            rpb   = (^rd) ^ ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) != 0);
            gap   = $urandom_range(0, 2);
            if (!prev_st && gap == 0) gap = 1;
            serial_a = 1'b1;
            tick(gap * BIT);
            frame_a(rd, rpb, rstop, -1);
            expq.push_back(model_a(rd, rpb, rstop));
            prev_st = rstop;
        end
        serial_a = 1'b1;
        tick(2 * BIT);
        check("rand_count", 32'(rxq_a.size()), 32'(expq.size()));
        for (int i = 0; i < 20; i++) begin
            if (expq.size() > 0) expect_a($sformatf("rand%0d", i), expq.pop_front());
        end

        // Config B: 7 data bits, no parity, two stop bits
        frame_b(7'h5A, 1'b1);
        serial_b = 1'b1;
        tick(BIT);
        check("b_5a_word", 32'({valid_b, data_b, perr_b, ferr_b, brk_b}), 32'({1'b1, 7'h5A, 3'b000}));

        // Reset mid-frame while a word is held
        for (int p = 0; p < 4 * BIT; p++) begin
            serial_b = (p < BIT) ? 1'b0 : p[4];
            tick(1);
        end
        serial_b = 1'b0;
        ready_b  = 1'b1;
        rst_n_b  = 1'b0;
        #1;
        check("b_midframe_reset_outs", 32'({valid_b, data_b, perr_b, ferr_b, brk_b, ovr_b}), 32'd0);
        tick(3);
        rst_n_b = 1'b1;
        tick(5 * BIT);
        check("b_low_after_reset_no_valid", 32'(valid_b), 32'd0);
        check("b_low_after_reset_no_word", 32'(rxq_b.size()), 32'd0);
        serial_b = 1'b1;
        tick(2 * BIT);
        frame_b(7'h2B, 1'b0);
        serial_b = 1'b1;
        tick(BIT);
        expect_b("b_2b_second_stop_low", {2'b0, 7'h2B, 1'b0, 1'b1, 1'b0});
        check("b_single", 32'(rxq_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
